// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the SD sector-engine request arbiter.
package sd_arb_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, XFER, RELEASE} sd_arb_state_t;
  localparam int SD_LBA_W = 32;
  localparam logic [23:0] SD_ARB_TIMEOUT_DEFAULT = 24'd4000000;
endpackage

// File: rtl/sd_request_arbiter_pick.sv
// Round-robin winner search: first pending bit after i_last_grant, wrapping.
// Purely combinational; o_any low means nothing is pending.
module rr_priority_pick
  import sd_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int GW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_pending,
  input  logic [GW-1:0]   i_last_grant,
  output logic [GW-1:0]   o_winner,
  output logic            o_any
);

  int w_pos;

  always_comb begin
    o_winner = '0;
    o_any    = 1'b0;
    w_pos    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_pos = (int'(i_last_grant) + k) % NREQ;
      if (!o_any && i_pending[w_pos]) begin
        o_winner = w_pos[GW-1:0];
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sd_request_arbiter.sv
// Shares one SD sector engine between NREQ requesters, one whole sector per grant,
// round-robin, with a watchdog on the engine busy/done handshake.
module sd_request_arbiter
  import sd_arb_pkg::*;
#(
  parameter int          NREQ    = 3,
  parameter logic [23:0] TIMEOUT = SD_ARB_TIMEOUT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ*SD_LBA_W-1:0] req_lba,
  input  logic [NREQ-1:0]          req_rd,
  input  logic [NREQ-1:0]          req_wr,
  output logic [NREQ-1:0]          req_busy,
  output logic [NREQ-1:0]          req_done,
  output logic [NREQ-1:0]          req_strobe,
  output logic [$clog2(NREQ)-1:0]  grant,
  output logic                     grant_valid,
  output logic [SD_LBA_W-1:0]      sd_lba,
  output logic                     sd_rd,
  output logic                     sd_wr,
  input  logic                     sd_busy,
  input  logic                     sd_done,
  input  logic                     sd_rd_byte_strobe,
  output logic                     timeout_err
);

  localparam int GW = $clog2(NREQ);

  sd_arb_state_t       r_state, w_state_nxt;
  logic [GW-1:0]       r_last_grant, r_grant, w_winner;
  logic                r_grant_valid, r_sd_rd, r_sd_wr, w_any, w_timeout;
  logic [SD_LBA_W-1:0] r_sd_lba;
  logic [23:0]         r_wdog;
  logic [NREQ-1:0]     w_pending;
  logic                w_wdog_zero, w_own_pending;

  assign w_pending     = req_rd | req_wr;
  assign w_own_pending = w_pending[r_grant];
  assign w_wdog_zero   = (r_wdog == 24'd0);

  rr_priority_pick #(.NREQ(NREQ), .GW(GW)) u_pick (
    .i_pending    (w_pending),
    .i_last_grant (r_last_grant),
    .o_winner     (w_winner),
    .o_any        (w_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE:    if (w_any) w_state_nxt = ISSUE;
      ISSUE: begin
        // Engine acceptance beats a same-cycle withdraw or watchdog expiry.
        if (sd_busy)             w_state_nxt = XFER;
        else if (!w_own_pending) w_state_nxt = IDLE;
        else if (w_wdog_zero) begin
          w_timeout   = 1'b1;
          w_state_nxt = RELEASE;
        end
      end
      XFER: begin
        if (sd_done) w_state_nxt = RELEASE;
        else if (w_wdog_zero) begin
          w_timeout   = 1'b1;
          w_state_nxt = RELEASE;
        end
      end
      RELEASE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_busy   = '0;
    req_done   = '0;
    req_strobe = '0;
    if (r_state == XFER) begin
      req_busy[r_grant]   = sd_busy;
      req_done[r_grant]   = sd_done;
      req_strobe[r_grant] = sd_rd_byte_strobe;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_last_grant  <= GW'(NREQ - 1);
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_sd_lba      <= '0;
      r_sd_rd       <= 1'b0;
      r_sd_wr       <= 1'b0;
      r_wdog        <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (!w_wdog_zero) r_wdog <= r_wdog - 24'd1;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant       <= w_winner;
            r_sd_lba      <= req_lba[SD_LBA_W*w_winner +: SD_LBA_W];
            r_sd_rd       <= req_rd[w_winner];
            r_sd_wr       <= req_wr[w_winner] & ~req_rd[w_winner];
            r_grant_valid <= 1'b1;
            r_wdog        <= TIMEOUT;
          end
        end
        ISSUE: begin
          if (w_state_nxt != ISSUE) begin
            r_sd_rd <= 1'b0;
            r_sd_wr <= 1'b0;
            if (sd_busy) r_wdog <= TIMEOUT;
            else         r_grant_valid <= 1'b0;
          end
        end
        XFER:    if (w_state_nxt == RELEASE) r_grant_valid <= 1'b0;
        RELEASE: begin
          r_last_grant  <= r_grant;
          r_grant_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_grant_valid;
  assign sd_lba      = r_sd_lba;
  assign sd_rd       = r_sd_rd;
  assign sd_wr       = r_sd_wr;
  assign timeout_err = w_timeout;

endmodule
